// File: rtl/instr_fetch_ctrl.sv
// Fetch/decode/sequencing stage: owns the 16-word instruction memory, latches IR
// and steers R15 of the downstream register file through PC_next every cycle.
module instr_fetch_ctrl #(
    parameter int          IMEM_DEPTH = 16,
    parameter logic [3:0]  OPC_HALT   = 4'hF
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        RUN,
    input  logic        IMEM_we,
    input  logic [3:0]  IMEM_waddr,
    input  logic [31:0] IMEM_wdata,
    input  logic [3:0]  PC_out,
    output logic [31:0] IR,
    output logic [3:0]  IR_ARd,
    output logic [3:0]  IR_ARn,
    output logic [3:0]  IR_ARm,
    output logic [3:0]  IR_ARs,
    output logic        CNTRL_write_en_ARd,
    output logic [3:0]  PC_next,
    output logic        halted
);

    localparam logic [3:0] OPC_LDR    = 4'h8;
    localparam logic [3:0] OPC_STR    = 4'h9;
    localparam logic [3:0] OPC_BRANCH = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] imem_q [IMEM_DEPTH];
    logic [3:0]  opcode;
    logic        is_mem_op;
    logic        writes_ard;

    assign opcode     = ir_q[31:28];
    assign is_mem_op  = (opcode == OPC_LDR) || (opcode == OPC_STR);
    assign writes_ard = (opcode <= OPC_LDR);

    assign IR     = ir_q;
    assign IR_ARd = ir_q[27:24];
    assign IR_ARn = ir_q[23:20];
    assign IR_ARm = ir_q[19:16];
    assign IR_ARs = ir_q[15:12];
    assign halted = (state_q == S_HALT);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Memory survives reset; a FETCH in the same cycle sees the pre-write word.
    always_ff @(posedge CLOCK_50) begin
        if (IMEM_we) begin
            imem_q[IMEM_waddr] <= IMEM_wdata;
        end
    end

    always_comb begin
        state_d            = state_q;
        ir_d               = ir_q;
        PC_next            = PC_out;
        CNTRL_write_en_ARd = 1'b0;

        case (state_q)
            S_IDLE: begin
                PC_next = 4'd0;
                if (RUN) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = imem_q[PC_out];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = is_mem_op ? S_MEM : S_WB;
            end
            S_MEM: begin
                state_d = S_WB;
            end
            S_WB: begin
                CNTRL_write_en_ARd = writes_ard;
                if (opcode == OPC_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    if (opcode == OPC_BRANCH) begin
                        PC_next = ir_q[3:0];
                    end else begin
                        PC_next = PC_out + 4'd1;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // R15 must clear on the reset edge, and an aborted instruction must not write.
        if (RESET) begin
            PC_next            = 4'd0;
            CNTRL_write_en_ARd = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a cycle-counting instruction model is
// compared on every falling edge, alongside hand-computed literal expectations.
module tb_instr_fetch_ctrl;

    logic        CLOCK_50;
    logic        RESET;
    logic        RUN;
    logic        IMEM_we;
    logic [3:0]  IMEM_waddr;
    logic [31:0] IMEM_wdata;
    logic [3:0]  pc_r = 4'd7;
    logic [31:0] IR;
    logic [3:0]  IR_ARd, IR_ARn, IR_ARm, IR_ARs;
    logic        CNTRL_write_en_ARd;
    logic [3:0]  PC_next;
    logic        halted;

    int error_count = 0;
    int check_count = 0;
    int we_pulses   = 0;

    instr_fetch_ctrl dut (
        .CLOCK_50           (CLOCK_50),
        .RESET              (RESET),
        .RUN                (RUN),
        .IMEM_we            (IMEM_we),
        .IMEM_waddr         (IMEM_waddr),
        .IMEM_wdata         (IMEM_wdata),
        .PC_out             (pc_r),
        .IR                 (IR),
        .IR_ARd             (IR_ARd),
        .IR_ARn             (IR_ARn),
        .IR_ARm             (IR_ARm),
        .IR_ARs             (IR_ARs),
        .CNTRL_write_en_ARd (CNTRL_write_en_ARd),
        .PC_next            (PC_next),
        .halted             (halted)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Stand-in for the register file's R15: rewritten from PC_next on every edge.
    always @(posedge CLOCK_50) pc_r <= PC_next;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count = check_count + 1;
        if (actual !== expected) begin
            error_count = error_count + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 = idle, 1 = running, 2 = halted; m_cyc counts 1..length within an instruction.
    int          m_mode = 0;
    int          m_cyc  = 0;
    logic [31:0] m_ir   = '0;
    logic [3:0]  m_pc   = 4'd7;
    logic [31:0] m_mem [16];
    bit          chk_en = 0;

    function automatic int instr_len(input logic [3:0] op);
        return (op == 4'h8 || op == 4'h9) ? 5 : 4;
    endfunction

    function automatic logic in_last_cycle();
        return (m_mode == 1) && (m_cyc == instr_len(m_ir[31:28]));
    endfunction

    function automatic logic [3:0] exp_pc_next();
        logic [3:0] op;
        op = m_ir[31:28];
        if (RESET || m_mode == 0) return 4'd0;
        if (in_last_cycle()) begin
            if (op == 4'hA) return m_ir[3:0];
            if (op == 4'hF) return m_pc;
            return m_pc + 4'd1;
        end
        return m_pc;
    endfunction

    function automatic logic exp_we();
        return !RESET && in_last_cycle() && (m_ir[31:28] <= 4'h8);
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    always @(posedge CLOCK_50) begin
        logic [3:0] nxt;
        nxt = exp_pc_next();
        if (RESET) begin
            chk_en = 1;
            m_mode = 0;
            m_cyc  = 0;
            m_ir   = '0;
        end else if (m_mode == 0) begin
            if (RUN) begin
                m_mode = 1;
                m_cyc  = 1;
            end
        end else if (m_mode == 1) begin
            if (m_cyc == 1) begin
                m_ir  = m_mem[m_pc];
                m_cyc = 2;
            end else if (m_cyc == instr_len(m_ir[31:28])) begin
                if (m_ir[31:28] == 4'hF) m_mode = 2;
                else m_cyc = 1;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end
        if (IMEM_we) m_mem[IMEM_waddr] = IMEM_wdata;
        m_pc = nxt;
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            checkOutput("model IR", IR, m_ir);
            checkOutput("model IR_ARd", {28'd0, IR_ARd}, {28'd0, m_ir[27:24]});
            checkOutput("model IR_ARn", {28'd0, IR_ARn}, {28'd0, m_ir[23:20]});
            checkOutput("model IR_ARm", {28'd0, IR_ARm}, {28'd0, m_ir[19:16]});
            checkOutput("model IR_ARs", {28'd0, IR_ARs}, {28'd0, m_ir[15:12]});
            checkOutput("model write_en", {31'd0, CNTRL_write_en_ARd}, {31'd0, exp_we()});
            checkOutput("model PC_next", {28'd0, PC_next}, {28'd0, exp_pc_next()});
            checkOutput("model halted", {31'd0, halted}, {31'd0, m_mode == 2});
            if (CNTRL_write_en_ARd === 1'b1) we_pulses = we_pulses + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic run, input logic we,
                                 input logic [3:0] addr, input logic [31:0] data);
        RUN        = run;
        IMEM_we    = we;
        IMEM_waddr = addr;
        IMEM_wdata = data;
        tick(1);
        RUN     = 1'b0;
        IMEM_we = 1'b0;
    endtask

    task automatic applyReset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
    endtask

    task automatic waitHalt(input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge CLOCK_50);
            if (halted === 1'b1) seen = 1;
        end
        if (!seen) checkOutput("halt timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] br_seq [4];

    initial begin
        br_seq = '{4'd0, 4'd14, 4'd15, 4'd0};
        RESET = 1'b1;
        RUN = 1'b0;
        IMEM_we = 1'b0;
        IMEM_waddr = '0;
        IMEM_wdata = '0;

        // Reset with PC_out=7: PC_next must already be 0 before the edge.
        #1;
        checkOutput("reset PC_next comb", {28'd0, PC_next}, 32'd0);
        tick(1);
        @(negedge CLOCK_50);
        checkOutput("reset IR", IR, 32'd0);
        checkOutput("reset write_en", {31'd0, CNTRL_write_en_ARd}, 32'd0);
        checkOutput("reset halted", {31'd0, halted}, 32'd0);
        checkOutput("reset PC_next", {28'd0, PC_next}, 32'd0);
        tick(1);
        RESET = 1'b0;

        // ALU sequence.
        $display("[TB] ALU then HALT");
        applyStimulus(0, 1, 4'd0, 32'h0312_4000);
        applyStimulus(0, 1, 4'd1, 32'hF000_0000);
        tick(3);
        @(negedge CLOCK_50);
        checkOutput("idle PC_next", {28'd0, PC_next}, 32'd0);
        we_pulses = 0;
        applyStimulus(1, 0, 4'd0, 32'd0);
        @(negedge CLOCK_50);
        checkOutput("alu fetch write_en", {31'd0, CNTRL_write_en_ARd}, 32'd0);
        tick(1);
        @(negedge CLOCK_50);
        checkOutput("alu IR", IR, 32'h0312_4000);
        checkOutput("alu ARd", {28'd0, IR_ARd}, 32'd3);
        checkOutput("alu ARn", {28'd0, IR_ARn}, 32'd1);
        checkOutput("alu ARm", {28'd0, IR_ARm}, 32'd2);
        checkOutput("alu ARs", {28'd0, IR_ARs}, 32'd4);
        tick(2);
        @(negedge CLOCK_50);
        checkOutput("alu wb write_en", {31'd0, CNTRL_write_en_ARd}, 32'd1);
        checkOutput("alu wb PC_next", {28'd0, PC_next}, 32'd1);
        waitHalt(20);
        checkOutput("halt PC_next", {28'd0, PC_next}, 32'd1);
        checkOutput("alu pulse count", we_pulses, 32'd1);
        applyStimulus(1, 0, 4'd0, 32'd0);
        tick(2);
        @(negedge CLOCK_50);
        checkOutput("halt ignores RUN", {31'd0, halted}, 32'd1);

        // LDR then STR.
        $display("[TB] LDR/STR timing");
        applyReset();
        applyStimulus(0, 1, 4'd0, 32'h8500_0000);
        applyStimulus(0, 1, 4'd1, 32'h9600_0000);
        applyStimulus(0, 1, 4'd2, 32'hF000_0000);
        we_pulses = 0;
        applyStimulus(1, 0, 4'd0, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLOCK_50);
            checkOutput("ldr write_en", {31'd0, CNTRL_write_en_ARd}, {31'd0, c == 5});
            checkOutput("ldr PC_out", {28'd0, pc_r}, 32'd0);
            if (c == 5) checkOutput("ldr PC_next", {28'd0, PC_next}, 32'd1);
            tick(1);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLOCK_50);
            checkOutput("str write_en", {31'd0, CNTRL_write_en_ARd}, 32'd0);
            checkOutput("str PC_out", {28'd0, pc_r}, 32'd1);
            if (c == 5) checkOutput("str PC_next", {28'd0, PC_next}, 32'd2);
            tick(1);
        end
        @(negedge CLOCK_50);
        checkOutput("after str PC_out", {28'd0, pc_r}, 32'd2);
        waitHalt(10);
        checkOutput("ldr/str pulse count", we_pulses, 32'd1);

        // Branch to 14, then wrap 15 -> 0.
        $display("[TB] branch and wrap");
        applyReset();
        applyStimulus(0, 1, 4'd0,  32'hA000_000E);
        applyStimulus(0, 1, 4'd14, 32'hB000_0000);
        applyStimulus(0, 1, 4'd15, 32'h0200_0000);
        we_pulses = 0;
        applyStimulus(1, 0, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            checkOutput("branch PC_out", {28'd0, pc_r}, {28'd0, br_seq[i]});
            if (i == 3) checkOutput("branch pulse count", we_pulses, 32'd1);
            tick(4);
        end

        // Reset during EXEC of an ALU op.
        $display("[TB] reset mid-instruction");
        applyReset();
        applyStimulus(0, 1, 4'd0, 32'h0100_0000);
        we_pulses = 0;
        applyStimulus(1, 0, 4'd0, 32'd0);
        tick(2);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("midreset PC_next", {28'd0, PC_next}, 32'd0);
        checkOutput("midreset write_en", {31'd0, CNTRL_write_en_ARd}, 32'd0);
        tick(1);
        RESET = 1'b0;
        tick(3);
        @(negedge CLOCK_50);
        checkOutput("midreset pulse count", we_pulses, 32'd0);
        checkOutput("midreset idle PC_next", {28'd0, PC_next}, 32'd0);
        checkOutput("midreset IR", IR, 32'd0);

        // Write address 2 during its own FETCH.
        $display("[TB] imem collision");
        applyReset();
        applyStimulus(0, 1, 4'd0, 32'hB000_0000);
        applyStimulus(0, 1, 4'd1, 32'hB000_0000);
        applyStimulus(0, 1, 4'd2, 32'h0700_0000);
        applyStimulus(0, 1, 4'd3, 32'hA000_0002);
        applyStimulus(1, 0, 4'd0, 32'd0);
        tick(8);
        @(negedge CLOCK_50);
        checkOutput("collision PC_out", {28'd0, pc_r}, 32'd2);
        applyStimulus(0, 1, 4'd2, 32'h0500_0000);
        @(negedge CLOCK_50);
        checkOutput("collision old word", IR, 32'h0700_0000);
        tick(8);
        @(negedge CLOCK_50);
        checkOutput("collision new word", IR, 32'h0500_0000);
        tick(2);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
